// File: rtl/hilo_md_unit.sv
// Multiply/divide unit with the HI/LO register pair: multi-cycle mult/div, mfhi/mflo reads,
// mthi/mtlo writes, and the stall flag the hazard unit watches while an op is in flight.
module hilo_md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  hilo_type,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        start,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] rdata,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        load, commit;
   logic        is_md, mt_ok;

   logic [63:0] prod;
   logic [31:0] dsor, mag_a, mag_b, quo, rem, res_hi, res_lo;
   logic        signed_op, is_div, res_we;

   assign is_md    = req && (hilo_type >= OP_MULT) && (hilo_type <= OP_DIVU);
   assign busy     = (state == RUN);
   assign start    = is_md && !busy && !flush;
   assign md_stall = start || busy;
   assign rdata    = (hilo_type == OP_MFHI) ? hi : lo;
   assign mt_ok    = req && !busy && !flush;

   // Divide works on magnitudes so INT_MIN / -1 wraps to 0x80000000 instead of trapping.
   always_comb begin
      is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
      signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
      dsor      = (b_q == 32'd0) ? 32'd1 : b_q;
      mag_a     = (signed_op && a_q[31]) ? -a_q : a_q;
      mag_b     = (signed_op && dsor[31]) ? -dsor : dsor;
      quo       = mag_a / mag_b;
      rem       = mag_a % mag_b;
      if (signed_op && (a_q[31] ^ dsor[31])) quo = -quo;
      if (signed_op && a_q[31])              rem = -rem;
      prod      = signed_op ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                            : ({32'd0, a_q} * {32'd0, b_q});
      res_hi    = is_div ? rem : prod[63:32];
      res_lo    = is_div ? quo : prod[31:0];
      res_we    = !(is_div && (b_q == 32'd0));
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
               cnt_n   = ((hilo_type == OP_MULT) || (hilo_type == OP_MULTU)) ?
                         4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end
         end
         RUN: begin
            if (flush) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else if (cnt == 4'd1) begin
               commit  = 1'b1;
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else begin
               cnt_n   = cnt - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt  <= 4'd0;
         op_q <= 4'd0;
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         hi   <= 32'd0;
         lo   <= 32'd0;
      end else begin
         cnt <= cnt_n;
         if (load) begin
            op_q <= hilo_type;
            a_q  <= a;
            b_q  <= b;
         end
         // A divide by zero still burns its cycles but leaves HI/LO alone.
         if (commit && res_we) begin
            hi <= res_hi;
            lo <= res_lo;
         end
         if (mt_ok && (hilo_type == OP_MTHI)) hi <= a;
         if (mt_ok && (hilo_type == OP_MTLO)) lo <= a;
      end
   end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: vector table for mult/div results plus hand sequences for
// reset, flush, divide-by-zero and requests arriving while busy.
module tb_hilo_md_unit;

   logic        clk, reset, req, flush;
   logic [3:0]  hilo_type;
   logic [31:0] a, b;
   logic        start, busy, md_stall;
   logic [31:0] rdata, hi, lo;

   int cmp_cnt = 0;
   int err_cnt = 0;

   hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .req(req), .hilo_type(hilo_type), .a(a), .b(b),
      .flush(flush), .start(start), .busy(busy), .md_stall(md_stall),
      .rdata(rdata), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a, b, hi, lo;
      int          cyc;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      req = 1'b1; hilo_type = op; a = v;
      tick();
      req = 1'b0; hilo_type = 4'd0;
   endtask

   // Issues one op, scrambles operands during RUN, and counts the busy cycles.
   task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] oa,
                         input logic [31:0] ob, input int cyc);
      int n;
      req = 1'b1; hilo_type = op; a = oa; b = ob;
      #1;
      chk({nm, "_start"}, 64'(start), 64'd1);
      chk({nm, "_stall"}, 64'(md_stall), 64'd1);
      tick();
      req = 1'b0; hilo_type = 4'd0; a = ~oa; b = 32'h5A5A_0003;
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      chk({nm, "_busycyc"}, 64'(n), 64'(cyc));
   endtask

   initial begin
      vecs[0] = '{"mult_neg1x2",   4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1] = '{"multu_ffx2",    4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2] = '{"mult_shift",    4'd1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
      vecs[3] = '{"div_m7_2",      4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[4] = '{"divu_7_2",      4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
      vecs[5] = '{"div_min_m1",    4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
      vecs[6] = '{"div_7_m2",      4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
      vecs[7] = '{"divu_max_10",   4'd4, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 10};

      reset = 1'b0; req = 1'b0; flush = 1'b0; hilo_type = 4'd0; a = '0; b = '0;
      tick(); tick();
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      req = 1'b1; hilo_type = 4'd1; #1;
      chk("rst_start_follows", 64'(start), 64'd1);
      req = 1'b0; hilo_type = 4'd0;
      reset = 1'b1;
      tick();

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc);
         chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
         chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
      end

      // Reset in the middle of a run.
      mt(4'd8, 32'h1234);
      chk("mthi_hi", 64'(hi), 64'h1234);
      req = 1'b1; hilo_type = 4'd1; a = 32'd2; b = 32'd3;
      tick();
      req = 1'b0; hilo_type = 4'd0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rstrun_busy", 64'(busy), 64'd0);
      chk("rstrun_hi", 64'(hi), 64'd0);
      chk("rstrun_lo", 64'(lo), 64'd0);

      // Divide by zero leaves HI/LO untouched.
      mt(4'd7, 32'hABCD);
      mt(4'd8, 32'h0077);
      run_op("divz", 4'd3, 32'd5, 32'd0, 10);
      chk("divz_lo", 64'(lo), 64'hABCD);
      chk("divz_hi", 64'(hi), 64'h0077);
      hilo_type = 4'd5; #1;
      chk("mflo_rdata", 64'(rdata), 64'hABCD);
      hilo_type = 4'd6; #1;
      chk("mfhi_rdata", 64'(rdata), 64'h0077);
      hilo_type = 4'd0;

      // Flush on the 3rd busy cycle.
      mt(4'd8, 32'h11);
      mt(4'd7, 32'h22);
      req = 1'b1; hilo_type = 4'd1; a = 32'd3; b = 32'd4;
      tick();
      req = 1'b0; hilo_type = 4'd0;
      tick(); tick();
      chk("fl3_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl3_busy", 64'(busy), 64'd0);
      chk("fl3_hi", 64'(hi), 64'h11);
      chk("fl3_lo", 64'(lo), 64'h22);

      // Flush on the final busy cycle beats the commit.
      req = 1'b1; hilo_type = 4'd2; a = 32'd9; b = 32'd9;
      tick();
      req = 1'b0; hilo_type = 4'd0;
      tick(); tick(); tick(); tick();
      chk("fl5_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl5_busy", 64'(busy), 64'd0);
      chk("fl5_lo", 64'(lo), 64'h22);

      // Flush blocks start and mthi in IDLE.
      req = 1'b1; hilo_type = 4'd3; a = 32'd8; b = 32'd2; flush = 1'b1; #1;
      chk("flst_start", 64'(start), 64'd0);
      chk("flst_stall", 64'(md_stall), 64'd0);
      tick();
      chk("flst_busy", 64'(busy), 64'd0);
      hilo_type = 4'd8; a = 32'hDEAD;
      tick();
      flush = 1'b0; req = 1'b0; hilo_type = 4'd0;
      chk("flmt_hi", 64'(hi), 64'h11);

      // No-ops: req=0 with an md code, and unused code 9.
      hilo_type = 4'd1; #1;
      chk("noreq_start", 64'(start), 64'd0);
      req = 1'b1; hilo_type = 4'd9; a = 32'hFFFF;
      tick();
      req = 1'b0; hilo_type = 4'd0;
      chk("code9_busy", 64'(busy), 64'd0);
      chk("code9_hi", 64'(hi), 64'h11);

      // mthi while busy is ignored; md_stall holds through every busy cycle.
      req = 1'b1; hilo_type = 4'd1; a = 32'd3; b = 32'd5;
      tick();
      req = 1'b0; hilo_type = 4'd0;
      for (int n = 1; n <= 5; n++) begin
         if (n == 2) begin
            req = 1'b1; hilo_type = 4'd8; a = 32'h55;
         end
         #1;
         chk($sformatf("bsy_stall_c%0d", n), 64'(md_stall), 64'd1);
         chk($sformatf("bsy_busy_c%0d", n), 64'(busy), 64'd1);
         tick();
         req = 1'b0; hilo_type = 4'd0;
      end
      chk("bsy_done", 64'(busy), 64'd0);
      chk("bsy_stall_done", 64'(md_stall), 64'd0);
      chk("bsy_hi", 64'(hi), 64'd0);
      chk("bsy_lo", 64'(lo), 64'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
